// File: rtl/axi_addr_window_slice.sv
// AXI4 AW/AR address-channel register slice with 2-entry skid buffers per channel.
// Addresses are aliased into a power-of-two window; out-of-window accepts are logged.

module axi_addr_window_slice_chan #(
    parameter int unsigned PW = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [PW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);

    logic          main_valid_r;
    logic [PW-1:0] main_data_r;
    logic          skid_valid_r;
    logic [PW-1:0] skid_data_r;

    logic          main_valid_s;
    logic [PW-1:0] main_data_s;
    logic          skid_valid_s;
    logic [PW-1:0] skid_data_s;
    logic          accept_s;
    logic          m_hs_s;

    // Ready depends only on the registered skid state; it is held low during reset.
    assign s_ready  = !skid_valid_r && !rst;
    assign accept_s = s_valid && s_ready;
    assign m_hs_s   = main_valid_r && m_ready;
    assign m_valid  = main_valid_r;
    assign m_data   = main_data_r;

    // Next-state of main/skid; an accept implies the skid is empty.
    always_comb begin
        main_valid_s = main_valid_r;
        main_data_s  = main_data_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        if (!main_valid_r || m_hs_s) begin
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_data_s  = skid_data_r;
                skid_valid_s = 1'b0;
            end else if (accept_s) begin
                main_valid_s = 1'b1;
                main_data_s  = s_data;
            end else begin
                main_valid_s = 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_s = 1'b1;
            skid_data_s  = s_data;
        end else begin
            skid_valid_s = skid_valid_r;
        end
    end

    // Main and skid registers; reset discards any buffered beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_data_r  <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
        end else begin
            main_valid_r <= main_valid_s;
            main_data_r  <= main_data_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
        end
    end

endmodule

module axi_addr_window_slice #(
    parameter int unsigned                    AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]      WIN_BASE       = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0]      WIN_SIZE       = 32'h1000_0000,
    parameter int unsigned                    CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic [7:0]                s_awlen_i,
    input  logic [2:0]                s_awsize_i,
    input  logic [1:0]                s_awburst_i,
    input  logic [2:0]                s_awprot_i,
    input  logic                      s_awvalid_i,
    output logic                      s_awready_o,

    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr_i,
    input  logic [7:0]                s_arlen_i,
    input  logic [2:0]                s_arsize_i,
    input  logic [1:0]                s_arburst_i,
    input  logic [2:0]                s_arprot_i,
    input  logic                      s_arvalid_i,
    output logic                      s_arready_o,

    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr_o,
    output logic [7:0]                m_awlen_o,
    output logic [2:0]                m_awsize_o,
    output logic [1:0]                m_awburst_o,
    output logic [2:0]                m_awprot_o,
    output logic                      m_awvalid_o,
    input  logic                      m_awready_i,

    output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
    output logic [7:0]                m_arlen_o,
    output logic [2:0]                m_arsize_o,
    output logic [1:0]                m_arburst_o,
    output logic [2:0]                m_arprot_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,

    input  logic                      err_clr_i,
    output logic                      oow_err_o,
    output logic [CNT_WIDTH-1:0]      oow_cnt_o
);

    localparam int unsigned PW = AXI_ADDR_WIDTH + 16;

    function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = addr - WIN_BASE;
        return (addr >= WIN_BASE) && (off < WIN_SIZE);
    endfunction

    // WIN_BASE is aligned to WIN_SIZE, so OR-ing in the offset aliases into the window.
    function automatic logic [AXI_ADDR_WIDTH-1:0] remap(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return WIN_BASE | (addr & (WIN_SIZE - {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1}));
    endfunction

    logic [PW-1:0]          aw_in_s;
    logic [PW-1:0]          ar_in_s;
    logic [PW-1:0]          aw_out_s;
    logic [PW-1:0]          ar_out_s;
    logic                   aw_oow_s;
    logic                   ar_oow_s;
    logic [1:0]             inc_s;
    logic [CNT_WIDTH-1:0]   cnt_base_s;
    logic [CNT_WIDTH:0]     cnt_sum_s;
    logic [CNT_WIDTH-1:0]   cnt_next_s;
    logic                   err_next_s;
    logic                   oow_err_r;
    logic [CNT_WIDTH-1:0]   oow_cnt_r;

    assign aw_in_s = {s_awprot_i, s_awburst_i, s_awsize_i, s_awlen_i, remap(s_awaddr_i)};
    assign ar_in_s = {s_arprot_i, s_arburst_i, s_arsize_i, s_arlen_i, remap(s_araddr_i)};

    axi_addr_window_slice_chan #(.PW(PW)) u_aw (
        .clk     (clk_i),
        .rst     (rst_i),
        .s_data  (aw_in_s),
        .s_valid (s_awvalid_i),
        .s_ready (s_awready_o),
        .m_data  (aw_out_s),
        .m_valid (m_awvalid_o),
        .m_ready (m_awready_i)
    );

    axi_addr_window_slice_chan #(.PW(PW)) u_ar (
        .clk     (clk_i),
        .rst     (rst_i),
        .s_data  (ar_in_s),
        .s_valid (s_arvalid_i),
        .s_ready (s_arready_o),
        .m_data  (ar_out_s),
        .m_valid (m_arvalid_o),
        .m_ready (m_arready_i)
    );

    assign {m_awprot_o, m_awburst_o, m_awsize_o, m_awlen_o, m_awaddr_o} = aw_out_s;
    assign {m_arprot_o, m_arburst_o, m_arsize_o, m_arlen_o, m_araddr_o} = ar_out_s;

    assign aw_oow_s = s_awvalid_i && s_awready_o && !in_window(s_awaddr_i);
    assign ar_oow_s = s_arvalid_i && s_arready_o && !in_window(s_araddr_i);
    assign inc_s    = {1'b0, aw_oow_s} + {1'b0, ar_oow_s};

    // Clear takes effect before this cycle's increment; the sum saturates at all-ones.
    always_comb begin
        cnt_base_s = err_clr_i ? '0 : oow_cnt_r;
        cnt_sum_s  = {1'b0, cnt_base_s} + {{(CNT_WIDTH-1){1'b0}}, inc_s};
        if (cnt_sum_s[CNT_WIDTH]) begin
            cnt_next_s = '1;
        end else begin
            cnt_next_s = cnt_sum_s[CNT_WIDTH-1:0];
        end
        err_next_s = (oow_err_r && !err_clr_i) || (inc_s != 2'd0);
    end

    // Error flag and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oow_err_r <= 1'b0;
            oow_cnt_r <= '0;
        end else begin
            oow_err_r <= err_next_s;
            oow_cnt_r <= cnt_next_s;
        end
    end

    assign oow_err_o = oow_err_r;
    assign oow_cnt_o = oow_cnt_r;

endmodule

// File: tb/tb_axi_addr_window_slice.sv
// Directed testbench for axi_addr_window_slice: reset, throughput, back-pressure,
// address aliasing, counter saturation/clear and reset mid-transfer.

module tb_axi_addr_window_slice;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] s_awaddr_i;
    logic [7:0]  s_awlen_i;
    logic [2:0]  s_awsize_i;
    logic [1:0]  s_awburst_i;
    logic [2:0]  s_awprot_i;
    logic        s_awvalid_i;
    logic        s_awready_o;
    logic [31:0] s_araddr_i;
    logic [7:0]  s_arlen_i;
    logic [2:0]  s_arsize_i;
    logic [1:0]  s_arburst_i;
    logic [2:0]  s_arprot_i;
    logic        s_arvalid_i;
    logic        s_arready_o;
    logic [31:0] m_awaddr_o;
    logic [7:0]  m_awlen_o;
    logic [2:0]  m_awsize_o;
    logic [1:0]  m_awburst_o;
    logic [2:0]  m_awprot_o;
    logic        m_awvalid_o;
    logic        m_awready_i;
    logic [31:0] m_araddr_o;
    logic [7:0]  m_arlen_o;
    logic [2:0]  m_arsize_o;
    logic [1:0]  m_arburst_o;
    logic [2:0]  m_arprot_o;
    logic        m_arvalid_o;
    logic        m_arready_i;
    logic        err_clr_i;
    logic        oow_err_o;
    logic [15:0] oow_cnt_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    axi_addr_window_slice dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_awaddr_i  (s_awaddr_i),
        .s_awlen_i   (s_awlen_i),
        .s_awsize_i  (s_awsize_i),
        .s_awburst_i (s_awburst_i),
        .s_awprot_i  (s_awprot_i),
        .s_awvalid_i (s_awvalid_i),
        .s_awready_o (s_awready_o),
        .s_araddr_i  (s_araddr_i),
        .s_arlen_i   (s_arlen_i),
        .s_arsize_i  (s_arsize_i),
        .s_arburst_i (s_arburst_i),
        .s_arprot_i  (s_arprot_i),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .m_awaddr_o  (m_awaddr_o),
        .m_awlen_o   (m_awlen_o),
        .m_awsize_o  (m_awsize_o),
        .m_awburst_o (m_awburst_o),
        .m_awprot_o  (m_awprot_o),
        .m_awvalid_o (m_awvalid_o),
        .m_awready_i (m_awready_i),
        .m_araddr_o  (m_araddr_o),
        .m_arlen_o   (m_arlen_o),
        .m_arsize_o  (m_arsize_o),
        .m_arburst_o (m_arburst_o),
        .m_arprot_o  (m_arprot_o),
        .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i),
        .err_clr_i   (err_clr_i),
        .oow_err_o   (oow_err_o),
        .oow_cnt_o   (oow_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        s_awaddr_i = 32'h0; s_awlen_i = 8'h0; s_awsize_i = 3'h0; s_awburst_i = 2'h0; s_awprot_i = 3'h0;
        s_awvalid_i = 1'b0;
        s_araddr_i = 32'h0; s_arlen_i = 8'h0; s_arsize_i = 3'h0; s_arburst_i = 2'h0; s_arprot_i = 3'h0;
        s_arvalid_i = 1'b0;
        m_awready_i = 1'b0; m_arready_i = 1'b0; err_clr_i = 1'b0;

        // Reset state
        step(); step();
        chk("rst_awready", s_awready_o, 1'b0);
        chk("rst_arready", s_arready_o, 1'b0);
        chk("rst_awvalid", m_awvalid_o, 1'b0);
        chk("rst_arvalid", m_arvalid_o, 1'b0);
        chk("rst_cnt", oow_cnt_o, 16'h0);
        chk("rst_err", oow_err_o, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_awready", s_awready_o, 1'b1);
        chk("post_rst_arready", s_arready_o, 1'b1);

        // Single in-window AW beat
        m_awready_i = 1'b1;
        s_awaddr_i = 32'h0000_1000; s_awlen_i = 8'h03; s_awsize_i = 3'h2; s_awburst_i = 2'h1; s_awprot_i = 3'h5;
        s_awvalid_i = 1'b1;
        step();
        s_awvalid_i = 1'b0;
        chk("aw1_valid", m_awvalid_o, 1'b1);
        chk("aw1_addr", m_awaddr_o, 32'h0000_1000);
        chk("aw1_len", m_awlen_o, 8'h03);
        chk("aw1_size", m_awsize_o, 3'h2);
        chk("aw1_burst", m_awburst_o, 2'h1);
        chk("aw1_prot", m_awprot_o, 3'h5);
        chk("aw1_cnt", oow_cnt_o, 16'h0);
        step();
        chk("aw1_drained", m_awvalid_o, 1'b0);

        // Eight back-to-back AR beats at full throughput
        m_arready_i = 1'b1;
        s_arvalid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_araddr_i = 32'h0000_2000 + 32'(i * 16);
            s_arlen_i  = 8'(i);
            chk("ar8_sready", s_arready_o, 1'b1);
            step();
            chk("ar8_mvalid", m_arvalid_o, 1'b1);
            chk("ar8_addr", m_araddr_o, 32'h0000_2000 + 32'(i * 16));
            chk("ar8_len", m_arlen_o, 8'(i));
        end
        s_arvalid_i = 1'b0;
        step();
        chk("ar8_drained", m_arvalid_o, 1'b0);

        // Back-pressure: three beats offered, two accepted
        m_awready_i = 1'b0;
        s_awlen_i = 8'h00;
        s_awaddr_i = 32'h0000_3000; s_awvalid_i = 1'b1;
        step();
        chk("bp_ready_a", s_awready_o, 1'b1);
        chk("bp_main_a", m_awaddr_o, 32'h0000_3000);
        s_awaddr_i = 32'h0000_3004;
        step();
        chk("bp_ready_b", s_awready_o, 1'b0);
        chk("bp_main_b", m_awaddr_o, 32'h0000_3000);
        s_awaddr_i = 32'h0000_3008;
        step();
        chk("bp_ready_c", s_awready_o, 1'b0);
        chk("bp_main_c", m_awaddr_o, 32'h0000_3000);
        chk("bp_valid_c", m_awvalid_o, 1'b1);
        s_awvalid_i = 1'b0;
        m_awready_i = 1'b1;
        step();
        chk("bp_drain1_valid", m_awvalid_o, 1'b1);
        chk("bp_drain1_addr", m_awaddr_o, 32'h0000_3004);
        chk("bp_drain1_ready", s_awready_o, 1'b1);
        step();
        chk("bp_drain2_valid", m_awvalid_o, 1'b0);
        chk("bp_cnt", oow_cnt_o, 16'h0);

        // Out-of-window aliasing on both channels in the same cycle
        s_awaddr_i = 32'h1000_0040; s_awvalid_i = 1'b1;
        s_araddr_i = 32'h2345_6780; s_arvalid_i = 1'b1;
        step();
        s_awvalid_i = 1'b0; s_arvalid_i = 1'b0;
        chk("oow_awaddr", m_awaddr_o, 32'h0000_0040);
        chk("oow_araddr", m_araddr_o, 32'h0345_6780);
        chk("oow_cnt2", oow_cnt_o, 16'h2);
        chk("oow_err", oow_err_o, 1'b1);
        step();

        // Clear, then drive the counter to 0xFFFE with 32767 dual accepts
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("clr_cnt", oow_cnt_o, 16'h0);
        chk("clr_err", oow_err_o, 1'b0);
        s_awaddr_i = 32'h1000_0000; s_araddr_i = 32'hF000_0000;
        s_awvalid_i = 1'b1; s_arvalid_i = 1'b1;
        repeat (32767) step();
        s_arvalid_i = 1'b0;
        chk("sat_pre", oow_cnt_o, 16'hFFFE);
        step();
        chk("sat_ffff", oow_cnt_o, 16'hFFFF);
        step();
        chk("sat_hold", oow_cnt_o, 16'hFFFF);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        s_awvalid_i = 1'b0;
        chk("clr_inc_cnt", oow_cnt_o, 16'h1);
        chk("clr_inc_err", oow_err_o, 1'b1);
        step();
        chk("idle_cnt", oow_cnt_o, 16'h1);

        // Reset while both skids are full
        m_awready_i = 1'b0; m_arready_i = 1'b0;
        s_awaddr_i = 32'h0000_5000; s_araddr_i = 32'h0000_6000;
        s_awvalid_i = 1'b1; s_arvalid_i = 1'b1;
        step();
        s_awaddr_i = 32'h0000_5004; s_araddr_i = 32'h0000_6004;
        step();
        s_awvalid_i = 1'b0; s_arvalid_i = 1'b0;
        chk("full_awready", s_awready_o, 1'b0);
        chk("full_arready", s_arready_o, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk("rr_awvalid", m_awvalid_o, 1'b0);
        chk("rr_arvalid", m_arvalid_o, 1'b0);
        chk("rr_awready", s_awready_o, 1'b1);
        chk("rr_arready", s_arready_o, 1'b1);
        chk("rr_cnt", oow_cnt_o, 16'h0);
        m_awready_i = 1'b1; m_arready_i = 1'b1;
        step();
        chk("rr_stale_aw", m_awvalid_o, 1'b0);
        chk("rr_stale_ar", m_arvalid_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
